// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data memory.
// After reset it optionally zero-fills the memory, then serves port 0 (LSU) and port 1 (debug/DMA).
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_dataIn,
    input  logic [DATA_WIDTH-1:0] mem_dataOut,

    output logic                  init_done
);

    localparam logic [0:0]            S_INIT   = 1'b0;
    localparam logic [0:0]            S_SERVE  = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [0:0]            S_RST    = (INIT_CLEAR != 0) ? S_INIT : S_SERVE;
    localparam logic                  DONE_RST = (INIT_CLEAR == 0);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rr_q, rr_d;
    logic                  done_q, done_d;
    logic                  rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DATA_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;

    logic                  g0, g1, we_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [DATA_WIDTH-1:0] din_c;

    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        we_c    = 1'b0;
        addr_c  = addr_q;
        din_c   = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rr_d    = rr_q;
        done_d  = done_q;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;

        if (state_q == S_INIT) begin
            we_c   = 1'b1;
            addr_c = cnt_q;
            cnt_d  = cnt_q + 1'b1;
            addr_d = cnt_q;
            if (cnt_q == CNT_LAST) begin
                state_d = S_SERVE;
                done_d  = 1'b1;
            end
        end else begin
            // rr_q names the port that wins a tie; it flips to the loser on every grant.
            g0 = p0_req & (~p1_req | ~rr_q);
            g1 = p1_req & (~p0_req |  rr_q);
            if (g0) begin
                we_c   = p0_we;
                addr_c = p0_addr;
                din_c  = p0_wdata;
                addr_d = p0_addr;
                rr_d   = 1'b1;
                if (!p0_we) begin
                    rv0_d = 1'b1;
                    rd0_d = mem_dataOut;
                end
            end else if (g1) begin
                we_c   = p1_we;
                addr_c = p1_addr;
                din_c  = p1_wdata;
                addr_d = p1_addr;
                rr_d   = 1'b0;
                if (!p1_we) begin
                    rv1_d = 1'b1;
                    rd1_d = mem_dataOut;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            addr_q  <= '0;
            rr_q    <= 1'b0;
            done_q  <= DONE_RST;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign p0_gnt      = g0 & rst_n;
    assign p1_gnt      = g1 & rst_n;
    assign mem_we      = we_c & rst_n;
    assign mem_address = rst_n ? addr_c : '0;
    assign mem_dataIn  = rst_n ? din_c : '0;

    assign p0_rvalid = rv0_q;
    assign p0_rdata  = rd0_q;
    assign p1_rvalid = rv1_q;
    assign p1_rdata  = rd1_q;
    assign init_done = done_q;

endmodule
